serial_to_parallel: RTL and testbench

Deserializer that rebuilds `width`-bit words from a single-bit serial stream sent least-significant-bit first. The serial input uses the same `serial_valid`/`serial_data` convention our parallel-to-serial converter drives, so the two blocks connect back to back. Each completed word is held in a one-entry output register and presented on a valid/ready interface. A sticky flag reports any word dropped because of downstream backpressure.

---
 rtl/serial_to_parallel.sv | 86 ++++++++
 tb/tb_serial_to_parallel.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// Deserializer: rebuilds width-bit words from an LSB-first serial stream and
// presents each word through a one-entry valid/ready output register.
module serial_to_parallel #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_valid,
   input  logic             serial_data,
   output logic             parallel_valid,
   output logic [width-1:0] parallel_data,
   input  logic             parallel_ready,
   output logic             busy,
   output logic             overflow
);

   localparam int cnt_w = (width > 2) ? $clog2(width) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);

   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [width-2:0] shift_q, shift_d;
   logic             valid_q, valid_d;
   logic [width-1:0] data_q, data_d;
   logic             overflow_q, overflow_d;

   logic word_done;
   logic reg_free;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      valid_d    = valid_q;
      data_d     = data_q;
      overflow_d = overflow_q;

      word_done = serial_valid && (cnt_q == last_cnt);
      // Draining and loading may happen on the same edge.
      reg_free  = !valid_q || parallel_ready;

      if (serial_valid) begin
         if (word_done) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + cnt_w'(1);
            for (int i = 0; i < width - 1; i++) begin
               if (cnt_q == cnt_w'(i)) shift_d[i] = serial_data;
            end
         end
      end

      if (valid_q && parallel_ready) valid_d = 1'b0;

      if (word_done) begin
         if (reg_free) begin
            valid_d = 1'b1;
            data_d  = {serial_data, shift_q};
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         shift_q    <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
      end
   end

   assign parallel_valid = valid_q;
   assign parallel_data  = data_q;
   assign overflow       = overflow_q;
   assign busy           = (cnt_q != '0);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (width = 8): single word, gapped bits,
// backpressure, overflow, simultaneous drain/load and asynchronous reset.
module tb_serial_to_parallel;

   localparam int width = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             serial_valid = 1'b0;
   logic             serial_data = 1'b0;
   logic             parallel_valid;
   logic [width-1:0] parallel_data;
   logic             parallel_ready = 1'b0;
   logic             busy;
   logic             overflow;

   int vectors = 0;
   int miscompares = 0;

   serial_to_parallel #(.width(width)) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_valid   (serial_valid),
      .serial_data    (serial_data),
      .parallel_valid (parallel_valid),
      .parallel_data  (parallel_data),
      .parallel_ready (parallel_ready),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge that consumed the inputs.
   task automatic send_bit(input logic b);
      serial_valid = 1'b1;
      serial_data  = b;
      @(posedge clk);
      #1;
      serial_valid = 1'b0;
      serial_data  = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_bit(w[i]);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #3;
      check("reset_valid", parallel_valid, 0);
      check("reset_data", parallel_data, 0);
      check("reset_busy", busy, 0);
      check("reset_ovf", overflow, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] w;

      // 1: single word 0xA5, no backpressure
      do_reset();
      parallel_ready = 1'b1;
      w = 8'hA5;
      for (int i = 0; i < 7; i++) begin
         send_bit(w[i]);
         check("s1_busy", busy, 1);
         check("s1_no_valid", parallel_valid, 0);
      end
      send_bit(w[7]);
      check("s1_valid", parallel_valid, 1);
      check("s1_data", parallel_data, 8'hA5);
      check("s1_busy_end", busy, 0);
      check("s1_ovf", overflow, 0);
      idle();
      check("s1_valid_one_cycle", parallel_valid, 0);
      check("s1_data_kept", parallel_data, 8'hA5);

      // 2: gapped bits of 0x3C
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         send_bit(w[i]);
         if (i < 7) begin
            check("s2_no_valid_bit", parallel_valid, 0);
            for (int g = 0; g <= i % 3; g++) begin
               idle();
               check("s2_no_valid_gap", parallel_valid, 0);
            end
         end
      end
      check("s2_valid", parallel_valid, 1);
      check("s2_data", parallel_data, 8'h3C);
      idle();
      check("s2_valid_drop", parallel_valid, 0);

      // 3: backpressure without loss
      parallel_ready = 1'b0;
      send_bits(8'h12, 0, 7);
      check("s3_first_valid", parallel_valid, 1);
      check("s3_first_data", parallel_data, 8'h12);
      w = 8'h34;
      for (int i = 0; i < 5; i++) begin
         send_bit(w[i]);
         check("s3_hold_valid", parallel_valid, 1);
         check("s3_hold_data", parallel_data, 8'h12);
      end
      parallel_ready = 1'b1;
      idle();
      parallel_ready = 1'b0;
      check("s3_drained", parallel_valid, 0);
      send_bits(8'h34, 5, 7);
      check("s3_second_valid", parallel_valid, 1);
      check("s3_second_data", parallel_data, 8'h34);
      check("s3_ovf", overflow, 0);
      parallel_ready = 1'b1;
      idle();
      check("s3_second_drained", parallel_valid, 0);

      // 4: overflow
      parallel_ready = 1'b0;
      send_bits(8'h12, 0, 7);
      send_bits(8'h34, 0, 6);
      check("s4_ovf_before", overflow, 0);
      send_bit(w[7]);
      check("s4_ovf_set", overflow, 1);
      check("s4_data_held", parallel_data, 8'h12);
      check("s4_valid_held", parallel_valid, 1);
      parallel_ready = 1'b1;
      idle();
      check("s4_drained", parallel_valid, 0);
      check("s4_data_last", parallel_data, 8'h12);
      idle();
      check("s4_no_second", parallel_valid, 0);
      check("s4_ovf_sticky", overflow, 1);

      // 5: simultaneous drain and load
      do_reset();
      parallel_ready = 1'b0;
      send_bits(8'h12, 0, 7);
      send_bits(8'h34, 0, 6);
      check("s5_held", parallel_data, 8'h12);
      parallel_ready = 1'b1;
      send_bit(w[7]);
      check("s5_valid", parallel_valid, 1);
      check("s5_data", parallel_data, 8'h34);
      check("s5_ovf", overflow, 0);
      idle();
      check("s5_drained", parallel_valid, 0);

      // contiguous words with ready held high
      send_bits(8'h5A, 0, 7);
      check("tp_data0", parallel_data, 8'h5A);
      send_bit(1'b1);
      check("tp_valid_gap", parallel_valid, 0);
      send_bits(8'hC3, 1, 7);
      check("tp_valid1", parallel_valid, 1);
      check("tp_data1", parallel_data, 8'hC3);
      check("tp_ovf", overflow, 0);

      // 6: reset mid-word
      send_bits(8'h0F, 0, 3);
      check("s6_busy_pre", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("s6_rst_valid", parallel_valid, 0);
      check("s6_rst_data", parallel_data, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_ovf", overflow, 0);
      @(negedge clk);
      rst = 1'b1;
      send_bits(8'hFF, 0, 3);
      check("s6_no_merge", parallel_valid, 0);
      send_bits(8'hFF, 4, 7);
      check("s6_valid", parallel_valid, 1);
      check("s6_data", parallel_data, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
